// File: rtl/snoop_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module : snoop_filter_pkg
// Brief  : Shared types and defaults for the snoop-filter maintenance engine.
// Rev    : 1.0  initial release
// ============================================================================
package snoop_filter_pkg;

    localparam int c_DEF_NSETS  = 64;
    localparam int c_DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        MNT_OP_INIT    = 2'd0,
        MNT_OP_SCAN    = 2'd1,
        MNT_OP_SINGLE  = 2'd2,
        MNT_OP_ILLEGAL = 2'd3
    } mnt_op_e;

    typedef enum logic [2:0] {
        MNT_ST_IDLE       = 3'd0,
        MNT_ST_INIT       = 3'd1,
        MNT_ST_SCAN       = 3'd2,
        MNT_ST_SCAN_DRAIN = 3'd3,
        MNT_ST_SINGLE     = 3'd4,
        MNT_ST_DONE       = 3'd5
    } mnt_state_e;

endpackage
`default_nettype wire

// File: rtl/snoop_filter_mnt_engine.sv
`default_nettype none
// ============================================================================
// Module : snoop_filter_mnt_engine
// Brief  : Muxes tag-pipeline lookups with INIT/SCAN/SINGLE maintenance onto
//          the snoop-filter tag array port.
// Rev    : 1.0  initial release
// ============================================================================
module snoop_filter_mnt_engine
    import snoop_filter_pkg::*;
#(
    parameter int  NSETS  = c_DEF_NSETS,
    parameter int  DATA_W = c_DEF_DATA_W,
    localparam int SET_W  = (NSETS > 1) ? $clog2(NSETS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mnt_req_valid,
    output logic              mnt_req_ready,
    input  logic [1:0]        mnt_req_op,
    input  logic [SET_W-1:0]  mnt_req_set,
    input  logic [DATA_W-1:0] mnt_req_data,
    input  logic              lkp_cen,
    input  logic              lkp_wen,
    input  logic [SET_W-1:0]  lkp_set_index,
    input  logic [DATA_W-1:0] lkp_data,
    output logic              lkp_stall,
    output logic              cen,
    output logic              wen,
    output logic [DATA_W-1:0] data,
    output logic [SET_W-1:0]  set_index,
    output logic              mnt_ops,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mnt_rsp_valid,
    output logic [SET_W-1:0]  mnt_rsp_set,
    output logic [DATA_W-1:0] mnt_rsp_data,
    output logic              mnt_busy,
    output logic              mnt_done,
    output logic              mnt_err
);

    localparam logic [2:0] c_S_IDLE       = MNT_ST_IDLE;
    localparam logic [2:0] c_S_INIT       = MNT_ST_INIT;
    localparam logic [2:0] c_S_SCAN       = MNT_ST_SCAN;
    localparam logic [2:0] c_S_SCAN_DRAIN = MNT_ST_SCAN_DRAIN;
    localparam logic [2:0] c_S_SINGLE     = MNT_ST_SINGLE;
    localparam logic [2:0] c_S_DONE       = MNT_ST_DONE;

    localparam logic [SET_W-1:0] c_LAST = SET_W'(NSETS - 1);

    logic [2:0]       r_state;
    logic [SET_W-1:0] r_cnt;
    logic             r_err;
    logic             r_rd_issued;
    logic [SET_W-1:0] r_rd_set;

    logic [2:0]       w_nxt_state;
    logic [SET_W-1:0] w_nxt_cnt;
    logic             w_nxt_err;
    logic             w_last;

    assign w_last        = (r_cnt == c_LAST);
    assign mnt_req_ready = (r_state == c_S_IDLE);
    assign lkp_stall     = !((r_state == c_S_IDLE) && !mnt_req_valid);
    assign mnt_busy      = (r_state != c_S_IDLE);
    assign mnt_done      = (r_state == c_S_DONE);
    assign mnt_err       = mnt_done & r_err;
    assign mnt_rsp_valid = r_rd_issued;
    assign mnt_rsp_set   = r_rd_set;
    assign mnt_rsp_data  = rd_data;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_err   = r_err;
        case (r_state)
            c_S_IDLE: begin
                if (mnt_req_valid) begin
                    w_nxt_cnt = '0;
                    w_nxt_err = 1'b0;
                    case (mnt_op_e'(mnt_req_op))
                        MNT_OP_INIT:   w_nxt_state = c_S_INIT;
                        MNT_OP_SCAN:   w_nxt_state = c_S_SCAN;
                        MNT_OP_SINGLE: w_nxt_state = c_S_SINGLE;
                        default: begin
                            w_nxt_state = c_S_DONE;
                            w_nxt_err   = 1'b1;
                        end
                    endcase
                end
            end
            c_S_INIT: begin
                if (w_last) w_nxt_state = c_S_DONE;
                else        w_nxt_cnt   = r_cnt + SET_W'(1);
            end
            c_S_SCAN: begin
                if (w_last) w_nxt_state = c_S_SCAN_DRAIN;
                else        w_nxt_cnt   = r_cnt + SET_W'(1);
            end
            c_S_SCAN_DRAIN: w_nxt_state = c_S_DONE;
            c_S_SINGLE:     w_nxt_state = c_S_DONE;
            c_S_DONE:       w_nxt_state = c_S_IDLE;
            default:        w_nxt_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_err   <= w_nxt_err;
        end
    end

    // Port registers are loaded from the next state so each access lines up
    // with the cycle the FSM spends in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cen       <= 1'b0;
            wen       <= 1'b0;
            mnt_ops   <= 1'b0;
            data      <= '0;
            set_index <= '0;
        end else begin
            cen     <= 1'b0;
            wen     <= 1'b0;
            mnt_ops <= 1'b0;
            case (w_nxt_state)
                c_S_INIT: begin
                    cen       <= 1'b1;
                    wen       <= 1'b1;
                    mnt_ops   <= 1'b1;
                    data      <= '0;
                    set_index <= w_nxt_cnt;
                end
                c_S_SCAN: begin
                    cen       <= 1'b1;
                    mnt_ops   <= 1'b1;
                    data      <= '0;
                    set_index <= w_nxt_cnt;
                end
                c_S_SINGLE: begin
                    cen       <= 1'b1;
                    wen       <= 1'b1;
                    mnt_ops   <= 1'b1;
                    data      <= mnt_req_data;
                    set_index <= mnt_req_set;
                end
                c_S_IDLE: begin
                    if (!lkp_stall && lkp_cen) begin
                        cen       <= 1'b1;
                        wen       <= lkp_wen;
                        data      <= lkp_data;
                        set_index <= lkp_set_index;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_issued <= 1'b0;
            r_rd_set    <= '0;
        end else begin
            r_rd_issued <= cen & ~wen & mnt_ops;
            r_rd_set    <= set_index;
        end
    end

endmodule
`default_nettype wire

// File: doc/snoop_filter_mnt_engine.md
Name: snoop_filter_mnt_engine

Overview:
Upstream driver of the snoop filter tag array port: the cen, wen, data, set_index and mnt_ops signals observed by the snoop-filter monitor interface.
Muxes functional lookup traffic from the tag pipeline with internally sequenced maintenance operations: INIT (zero every set), SCAN (read every set out) and SINGLE (write one set).
Maintenance owns the array while busy; lookups are stalled back to the tag pipeline.

Parameters:
NSETS, 64, number of sets; any value >= 1, power of two not required.
DATA_W, 64, array word width (all ways of one set packed).
SET_W, $clog2(NSETS) (min 1), set index width; derived, not overridden.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mnt_req_valid  in  1  maintenance request valid
mnt_req_ready  out  1  maintenance request ready
mnt_req_op  in  2  0=INIT, 1=SCAN, 2=SINGLE, 3=illegal
mnt_req_set  in  SET_W  target set (SINGLE only)
mnt_req_data  in  DATA_W  write data (SINGLE only)
lkp_cen  in  1  lookup access enable
lkp_wen  in  1  lookup write enable
lkp_set_index  in  SET_W  lookup set
lkp_data  in  DATA_W  lookup write data
lkp_stall  out  1  lookup not taken this cycle
cen  out  1  array chip enable (registered)
wen  out  1  array write enable (registered)
data  out  DATA_W  array write data (registered)
set_index  out  SET_W  array set index (registered)
mnt_ops  out  1  current array access is maintenance (registered)
rd_data  in  DATA_W  array read data, valid 1 cycle after a read access
mnt_rsp_valid  out  1  SCAN read data valid
mnt_rsp_set  out  SET_W  set of mnt_rsp_data
mnt_rsp_data  out  DATA_W  SCAN read data (= rd_data)
mnt_busy  out  1  state != IDLE
mnt_done  out  1  1-cycle completion pulse
mnt_err  out  1  1-cycle pulse with mnt_done for illegal op

Behaviour:
- Reset values:
  - All registered outputs: 0.
  - FSM in IDLE, set counter 0.
  - mnt_req_ready = 1.
  - lkp_stall follows mnt_req_valid.
  - mnt_rsp_valid, mnt_done, mnt_err = 0.
- FSM states: IDLE, INIT, SCAN, SCAN_DRAIN, SINGLE, DONE.
- IDLE:
  - mnt_req_ready = 1.
  - Request accepted when mnt_req_valid & mnt_req_ready.
  - Op decode: INIT->INIT, SCAN->SCAN, SINGLE->SINGLE, op 3->DONE with error flag set.
  - Counter cleared on accept.
- Arbitration:
  - lkp_stall = !(state==IDLE && !mnt_req_valid).
  - A maintenance request always beats a same-cycle lookup.
  - An unstalled lookup drives the port next cycle: cen=lkp_cen, wen=lkp_wen, set_index/data copied, mnt_ops=0.
  - lkp_cen=0 when unstalled -> cen=0 next cycle.
- INIT:
  - One write per cycle: cen=1, wen=1, mnt_ops=1, data=0, set_index=counter.
  - Counter increments each cycle.
  - After set NSETS-1 -> DONE.
  - Accept at cycle T: writes occupy T+1..T+NSETS, mnt_done at T+NSETS+1.
- SCAN:
  - Same cadence as INIT but reads: cen=1, wen=0, data=0.
  - After the last read -> SCAN_DRAIN for 1 cycle, then DONE.
  - A registered read-issued flag and set copy drive mnt_rsp_valid, mnt_rsp_set and mnt_rsp_data=rd_data in the cycle after each read.
  - No backpressure; the consumer must take every beat.
  - Responses at T+2..T+NSETS+1, mnt_done at T+NSETS+2.
- SINGLE:
  - One write of the captured mnt_req_set/mnt_req_data with mnt_ops=1 at T+1.
  - mnt_done at T+2.
- DONE:
  - mnt_done=1 (and mnt_err if illegal op) for exactly one cycle.
  - Port idle (cen=0) in this cycle; lookups still stalled.
  - IDLE next cycle.
- Counter:
  - SET_W bits; terminal compare against NSETS-1, never natural wrap.
  - NSETS=1: a single access, then DONE.
- Port idle in IDLE with no lookup: cen=wen=mnt_ops=0; data and set_index held.
- mnt_req_* inputs are ignored while not IDLE.
- Reset mid-operation:
  - Asynchronous abort: outputs cleared immediately, FSM to IDLE.
  - In-flight SCAN response dropped; no mnt_done.

Decomposition:
- Shared package snoop_filter_pkg:
  - mnt_op_e enum (INIT, SCAN, SINGLE, ILLEGAL).
  - mnt_state_e FSM enum.
  - Default NSETS/DATA_W constants.
- No sub-module; counter and FSM are inline, single module.

Test Plan:
- INIT, NSETS=64, accept at T -> cen=wen=mnt_ops=1, data=0, set_index 0..63 on T+1..T+64; mnt_done at T+65; mnt_busy high T+1..T+65.
- SCAN after backdoor load data[i]=i*0x0101 -> 64 mnt_rsp_valid beats, set 0..63 in order, data matching; mnt_done at T+66.
- SINGLE set=17, data=0xDEAD_BEEF -> single write at T+1 with set_index=17, mnt_ops=1; mnt_done at T+2; no other accesses.
- mnt_req_valid and lkp_cen=1 in the same IDLE cycle -> lkp_stall=1, maintenance wins; the lookup retried after DONE appears with mnt_ops=0 one cycle after acceptance.
- rst_n low during INIT at set 30 -> outputs 0 immediately, no mnt_done; a new INIT restarts at set 0.
- op=3 -> no array access; mnt_done and mnt_err pulse together at T+1; mnt_req_ready back at T+2.
